// File: rtl/pipelined_dual_port_blockram.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_dual_port_blockram
// Purpose  : Independent read/write block RAM with lane-masked writes, evict
//            readout of the overwritten entry, optional output register and a
//            post-reset clearing sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_dual_port_blockram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUMBER_SET                = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = 6,
    parameter int WRITE_MASK_WIDTH          = 8,
    parameter int OUTPUT_REG                = 1
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    output logic                                 init_busy_out,
    input  logic                                 read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
    output logic                                 read_valid_out,
    input  logic                                 write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_set_addr_in,
    input  logic [WRITE_MASK_WIDTH-1:0]          write_mask_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] evict_entry_out,
    output logic                                 evict_valid_out
);

    localparam int c_LANE = SINGLE_ENTRY_SIZE_IN_BITS / WRITE_MASK_WIDTH;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] c_LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SET - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                               r_state;
    state_t                               w_state_next;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     r_init_cnt;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_mem [0:NUMBER_SET-1];

    logic                                 w_ready;
    logic                                 w_rd_accept;
    logic                                 w_wr_accept;
    logic                                 w_rd_in_range;
    logic                                 w_wr_in_range;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] w_rd_old;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] w_wr_old;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] w_wr_merged;

    logic                                 r_rd_valid_s1;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_rd_data_s1;
    logic                                 r_ev_valid_s1;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_ev_data_s1;

    // Busy is gated by reset so every output reads zero while reset is held.
    assign init_busy_out = (r_state == ST_INIT) && !reset_in;
    assign w_ready       = (r_state == ST_READY) && !reset_in;
    assign w_rd_accept   = read_en_in && w_ready;
    assign w_wr_accept   = write_en_in && w_ready;

    assign w_rd_in_range = 32'(read_set_addr_in) < NUMBER_SET;
    assign w_wr_in_range = 32'(write_set_addr_in) < NUMBER_SET;
    assign w_rd_old      = w_rd_in_range ? r_mem[read_set_addr_in] : '0;
    assign w_wr_old      = w_wr_in_range ? r_mem[write_set_addr_in] : '0;

    for (genvar g = 0; g < WRITE_MASK_WIDTH; g++) begin : g_lane
        assign w_wr_merged[g*c_LANE +: c_LANE] = write_mask_in[g] ?
            write_entry_in[g*c_LANE +: c_LANE] : w_wr_old[g*c_LANE +: c_LANE];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:  if (r_init_cnt == c_LAST_SET) w_state_next = ST_READY;
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT && r_init_cnt != c_LAST_SET)
                r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    // Array is not reset; the sequencer defines its contents after reset.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            if (r_state == ST_INIT)
                r_mem[r_init_cnt] <= '0;
            else if (w_wr_accept && w_wr_in_range)
                r_mem[write_set_addr_in] <= w_wr_merged;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_rd_valid_s1 <= 1'b0;
            r_rd_data_s1  <= '0;
            r_ev_valid_s1 <= 1'b0;
            r_ev_data_s1  <= '0;
        end else begin
            r_rd_valid_s1 <= w_rd_accept;
            r_ev_valid_s1 <= w_wr_accept;
            if (w_rd_accept) r_rd_data_s1 <= w_rd_old;
            if (w_wr_accept) r_ev_data_s1 <= w_wr_old;
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic                                 r_rd_valid_s2;
        logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_rd_data_s2;
        logic                                 r_ev_valid_s2;
        logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_ev_data_s2;

        always_ff @(posedge clk_in) begin
            if (reset_in) begin
                r_rd_valid_s2 <= 1'b0;
                r_rd_data_s2  <= '0;
                r_ev_valid_s2 <= 1'b0;
                r_ev_data_s2  <= '0;
            end else begin
                r_rd_valid_s2 <= r_rd_valid_s1;
                r_ev_valid_s2 <= r_ev_valid_s1;
                if (r_rd_valid_s1) r_rd_data_s2 <= r_rd_data_s1;
                if (r_ev_valid_s1) r_ev_data_s2 <= r_ev_data_s1;
            end
        end

        assign read_valid_out  = r_rd_valid_s2;
        assign read_entry_out  = r_rd_data_s2;
        assign evict_valid_out = r_ev_valid_s2;
        assign evict_entry_out = r_ev_data_s2;
    end else begin : g_no_out_reg
        assign read_valid_out  = r_rd_valid_s1;
        assign read_entry_out  = r_rd_data_s1;
        assign evict_valid_out = r_ev_valid_s1;
        assign evict_entry_out = r_ev_data_s1;
    end

endmodule
`default_nettype wire
